bdc_cmd_sequencer: RTL and testbench
====================================

# bdc_cmd_sequencer

Sits directly upstream of the BDM byte engine and turns one complete BDC command into a sequence of single-byte `do_write` / `do_delay` / `do_read` strobes. The command carries an opcode, an optional 16-bit address, 0–2 write bytes, an optional ACK-substitute delay and 0–2 read bytes. Read bytes are collected into a single response word. The host-side decoder (UART command parser) talks only to this block and never strobes the byte engine directly.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1048576: per-byte watchdog limit, in clk cycles, before the command is aborted with an error.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_opcode`  in  8  BDC opcode byte
- `cmd_has_addr`  in  1  send `cmd_addr`, high byte first
- `cmd_addr`  in  16  target address
- `cmd_wr_len`  in  2  write bytes, 0–2; value 3 is treated as 2
- `cmd_wdata`  in  16  write data; for length 2, `[15:8]` goes first; for length 1, only `[7:0]` is sent
- `cmd_delay`  in  8  delay argument for the byte engine; 0 skips the delay step
- `cmd_rd_len`  in  2  read bytes, 0–2; value 3 is treated as 2
- `bdm_ready`  in  1  byte engine idle
- `bdm_valid`  in  1  byte engine read data valid (one-cycle pulse)
- `bdm_data_out`  in  8  byte engine read data
- `bdm_do_write`  out  1  one-cycle write strobe
- `bdm_do_read`  out  1  one-cycle read strobe
- `bdm_do_delay`  out  1  one-cycle delay strobe
- `bdm_data_in`  out  8  byte for write/delay; held stable from strobe until `bdm_ready` returns
- `rsp_valid`  out  1  one-cycle pulse: command finished
- `rsp_data`  out  16  read bytes, first byte in `[15:8]` when 2 read; single byte in `[7:0]`; 0 when none
- `rsp_error`  out  1  qualifies `rsp_valid`: watchdog fired

## Operation
- Command is accepted on `cmd_valid && cmd_ready`. All fields are latched; inputs are ignored afterwards.
- Step list is built at accept, in this order:
  - opcode
  - addr[15:8], addr[7:0] (only if `cmd_has_addr`)
  - write bytes
  - delay (only if `cmd_delay != 0`)
  - read bytes
- Maximum 8 steps. The opcode step is always present.
- States:
  - IDLE: `cmd_ready=1`. Accept goes to ISSUE.
  - ISSUE: waits for `bdm_ready=1`, then drives exactly one strobe for one cycle with `bdm_data_in` set. Goes to WAIT.
  - WAIT: completion is `bdm_ready=1` for write/delay steps and `bdm_valid=1` for read steps. On a read, `bdm_data_out` is shifted into `rsp_data` (`rsp_data <= {rsp_data[7:0], byte}`). On completion, go to ISSUE if steps remain, otherwise DONE.
  - DONE: `rsp_valid=1` for one cycle, then IDLE.
- All strobes are registered; none may depend combinationally on `bdm_ready`. The byte engine's ready drops combinationally while a strobe is high.
- WAIT ignores `bdm_ready` in the cycle immediately after the strobe, because the byte engine leaves idle only on the next edge.
- Watchdog:
  - Counter clears on every state entry and counts in ISSUE and WAIT.
  - On reaching `TIMEOUT_CYCLES`: abort the remaining steps, go to DONE with `rsp_error=1`, and `rsp_data` holds whatever bytes were shifted in so far.
- `rsp_data` clears to 0 at accept.

## Timing
- Reset values: `cmd_ready=1`, all strobes 0, `bdm_data_in=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_error=0`, state IDLE, watchdog 0.
- Reset mid-command: abandons immediately with no `rsp_valid`. The byte engine is reset by the same `rst`.
- Accept edge to first strobe: 1 cycle if `bdm_ready` is already high.
- Write step completion (`bdm_ready` high) to next strobe: 1 cycle.
- Last completion to `rsp_valid`: 1 cycle.
- `cmd_ready` goes low the cycle after accept and returns high the cycle after `rsp_valid`.
- A `bdm_valid` seen outside a read WAIT is ignored.

## Structure
- The shared BDM package holds:
  - step-kind encoding (WRITE, DELAY, READ)
  - state encoding
  - `MAX_STEPS=8`
- Natural sub-module: `bdc_step_builder`, a combinational block mapping latched command fields to a step-kind array, byte array and step count. The sequencer holds a 3-bit step index into these arrays.
- Watchdog width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Opcode 0xE4, no address, `wr_len=0`, `rd_len=1`; engine returns 0xC8. Required: a single write strobe of 0xE4, then one read strobe, then `rsp_valid` with `rsp_data=0x00C8`.
- Opcode 0x4B, `addr=0x1234`, `wr_len=1`, `wdata=0x0055`, `delay=0x10`. Required: write strobes 0x4B, 0x12, 0x34, 0x55, then a delay strobe with `data_in=0x10`, then `rsp_valid` with `rsp_data=0`.
- `rd_len=2`; engine returns 0xAB then 0xCD. Required: `rsp_data=0xABCD`.
- Hold `bdm_ready=0` with `TIMEOUT_CYCLES=100`. Required: no strobe, and `rsp_valid` with `rsp_error=1` exactly 100 cycles after entering ISSUE.
- Assert `rst` between the 2nd and 3rd strobes. Required: no further strobes, no `rsp_valid`, `cmd_ready=1` the cycle after reset.
- Present a second command while busy. Required: not accepted until the cycle after `rsp_valid`; its fields are latched only then.

Source files
------------

// File: rtl/bdc_cmd_sequencer_pkg.sv
// Shared types and constants for the BDC command sequencer.
package bdc_cmd_sequencer_pkg;

  localparam int unsigned MAX_STEPS  = 8;
  localparam int unsigned STEP_IDX_W = $clog2(MAX_STEPS);
  localparam int unsigned STEP_CNT_W = STEP_IDX_W + 1;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 16;

  typedef enum logic [1:0] {
    STEP_WRITE = 2'd0,
    STEP_DELAY = 2'd1,
    STEP_READ  = 2'd2
  } step_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] opcode;
    logic              has_addr;
    logic [WORD_W-1:0] addr;
    logic [1:0]        wr_len;
    logic [WORD_W-1:0] wdata;
    logic [BYTE_W-1:0] delay;
    logic [1:0]        rd_len;
  } bdc_cmd_t;

  // Byte counts above two are treated as two.
  function automatic logic [1:0] clamp_len(input logic [1:0] len);
    return (len == 2'd3) ? 2'd2 : len;
  endfunction

endpackage

// File: rtl/bdc_step_builder.sv
// Expands a latched BDC command into an ordered list of byte-engine steps.
module bdc_step_builder
  import bdc_cmd_sequencer_pkg::*;
(
  input  bdc_cmd_t                         cmd_i,
  output step_kind_e [MAX_STEPS-1:0]       step_kind_o,
  output logic [MAX_STEPS-1:0][BYTE_W-1:0] step_byte_o,
  output logic [STEP_CNT_W-1:0]            step_cnt_o
);

  logic [1:0]            wr_len;
  logic [1:0]            rd_len;
  logic [STEP_CNT_W-1:0] n;

  // Append steps in wire order: opcode, address, write data, delay, reads.
  always_comb begin
    for (int unsigned i = 0; i < MAX_STEPS; i++) begin
      step_kind_o[i] = STEP_WRITE;
      step_byte_o[i] = '0;
    end
    wr_len = clamp_len(cmd_i.wr_len);
    rd_len = clamp_len(cmd_i.rd_len);
    n      = '0;

    step_byte_o[n[STEP_IDX_W-1:0]] = cmd_i.opcode;
    n = n + STEP_CNT_W'(1);

    if (cmd_i.has_addr) begin
      step_byte_o[n[STEP_IDX_W-1:0]] = cmd_i.addr[15:8];
      n = n + STEP_CNT_W'(1);
      step_byte_o[n[STEP_IDX_W-1:0]] = cmd_i.addr[7:0];
      n = n + STEP_CNT_W'(1);
    end

    if (wr_len == 2'd2) begin
      step_byte_o[n[STEP_IDX_W-1:0]] = cmd_i.wdata[15:8];
      n = n + STEP_CNT_W'(1);
    end
    if (wr_len != 2'd0) begin
      step_byte_o[n[STEP_IDX_W-1:0]] = cmd_i.wdata[7:0];
      n = n + STEP_CNT_W'(1);
    end

    if (cmd_i.delay != '0) begin
      step_kind_o[n[STEP_IDX_W-1:0]] = STEP_DELAY;
      step_byte_o[n[STEP_IDX_W-1:0]] = cmd_i.delay;
      n = n + STEP_CNT_W'(1);
    end

    for (int r = 0; r < 2; r++) begin
      if (2'(r) < rd_len) begin
        step_kind_o[n[STEP_IDX_W-1:0]] = STEP_READ;
        n = n + STEP_CNT_W'(1);
      end
    end

    step_cnt_o = n;
  end

endmodule

// File: rtl/bdc_cmd_sequencer.sv
// Turns one BDC command into single-byte strobes for the BDM byte engine.
module bdc_cmd_sequencer
  import bdc_cmd_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BYTE_W-1:0] cmd_opcode,
  input  logic              cmd_has_addr,
  input  logic [WORD_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_wr_len,
  input  logic [WORD_W-1:0] cmd_wdata,
  input  logic [BYTE_W-1:0] cmd_delay,
  input  logic [1:0]        cmd_rd_len,
  input  logic              bdm_ready,
  input  logic              bdm_valid,
  input  logic [BYTE_W-1:0] bdm_data_out,
  output logic              bdm_do_write,
  output logic              bdm_do_read,
  output logic              bdm_do_delay,
  output logic [BYTE_W-1:0] bdm_data_in,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_error
);

  localparam int unsigned       WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  state_e                           state_q, state_d;
  bdc_cmd_t                         cmd_q, cmd_d, cmd_in;
  logic [STEP_IDX_W-1:0]            idx_q, idx_d;
  logic [WDOG_W-1:0]                wdog_q, wdog_d;
  logic                             cmd_ready_q, cmd_ready_d;
  logic                             do_write_q, do_write_d;
  logic                             do_read_q, do_read_d;
  logic                             do_delay_q, do_delay_d;
  logic [BYTE_W-1:0]                data_in_q, data_in_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic                             rsp_error_q, rsp_error_d;
  logic [WORD_W-1:0]                rsp_data_q, rsp_data_d;

  step_kind_e [MAX_STEPS-1:0]       step_kind;
  logic [MAX_STEPS-1:0][BYTE_W-1:0] step_byte;
  logic [STEP_CNT_W-1:0]            step_cnt;
  step_kind_e                       cur_kind;
  logic                             last_step;
  logic                             wdog_hit;
  logic                             strobe_cycle;
  logic                             step_done;

  assign cmd_in = '{opcode:   cmd_opcode,
                    has_addr: cmd_has_addr,
                    addr:     cmd_addr,
                    wr_len:   cmd_wr_len,
                    wdata:    cmd_wdata,
                    delay:    cmd_delay,
                    rd_len:   cmd_rd_len};

  bdc_step_builder u_step_builder (
    .cmd_i       (cmd_q),
    .step_kind_o (step_kind),
    .step_byte_o (step_byte),
    .step_cnt_o  (step_cnt)
  );

  assign cur_kind     = step_kind[idx_q];
  assign last_step    = (({1'b0, idx_q} + STEP_CNT_W'(1)) == step_cnt);
  assign wdog_hit     = (wdog_q == WDOG_LAST);
  // The engine is still idle during the strobe cycle, so its ready is not yet meaningful.
  assign strobe_cycle = do_write_q | do_read_q | do_delay_q;
  assign step_done    = !strobe_cycle && ((cur_kind == STEP_READ) ? bdm_valid : bdm_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, strobe, response and watchdog logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    cmd_ready_d = cmd_ready_q;
    do_write_d  = 1'b0;
    do_read_d   = 1'b0;
    do_delay_d  = 1'b0;
    data_in_d   = data_in_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d       = cmd_in;
          idx_d       = '0;
          wdog_d      = '0;
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bdm_ready) begin
          case (cur_kind)
            STEP_WRITE: do_write_d = 1'b1;
            STEP_DELAY: do_delay_d = 1'b1;
            default:    do_read_d  = 1'b1;
          endcase
          data_in_d = step_byte[idx_q];
          wdog_d    = '0;
          state_d   = ST_WAIT;
        end else if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          wdog_d      = '0;
          state_d     = ST_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_WAIT: begin
        if (step_done) begin
          if (cur_kind == STEP_READ) rsp_data_d = {rsp_data_q[7:0], bdm_data_out};
          wdog_d = '0;
          if (last_step) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            idx_d   = idx_q + STEP_IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end else if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          wdog_d      = '0;
          state_d     = ST_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        wdog_d      = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      idx_q       <= '0;
      wdog_q      <= '0;
      cmd_ready_q <= 1'b1;
      do_write_q  <= 1'b0;
      do_read_q   <= 1'b0;
      do_delay_q  <= 1'b0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      cmd_ready_q <= cmd_ready_d;
      do_write_q  <= do_write_d;
      do_read_q   <= do_read_d;
      do_delay_q  <= do_delay_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign bdm_do_write = do_write_q;
  assign bdm_do_read  = do_read_q;
  assign bdm_do_delay = do_delay_q;
  assign bdm_data_in  = data_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_bdc_cmd_sequencer.sv
// Bench for bdc_cmd_sequencer: byte-engine model, step-list reference model, scenario tasks.
`timescale 1ns/1ps
module tb_bdc_cmd_sequencer;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic        cmd_has_addr;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_wr_len;
  logic [15:0] cmd_wdata;
  logic [7:0]  cmd_delay;
  logic [1:0]  cmd_rd_len;
  logic        bdm_ready;
  logic        bdm_valid;
  logic [7:0]  bdm_data_out;
  logic        bdm_do_write;
  logic        bdm_do_read;
  logic        bdm_do_delay;
  logic [7:0]  bdm_data_in;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;

  bdc_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_has_addr (cmd_has_addr),
    .cmd_addr     (cmd_addr),
    .cmd_wr_len   (cmd_wr_len),
    .cmd_wdata    (cmd_wdata),
    .cmd_delay    (cmd_delay),
    .cmd_rd_len   (cmd_rd_len),
    .bdm_ready    (bdm_ready),
    .bdm_valid    (bdm_valid),
    .bdm_data_out (bdm_data_out),
    .bdm_do_write (bdm_do_write),
    .bdm_do_read  (bdm_do_read),
    .bdm_do_delay (bdm_do_delay),
    .bdm_data_in  (bdm_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Byte-engine model state and logs.
  logic       eng_idle = 1'b1;
  logic       hold_rdy = 1'b0;
  bit         stray_en = 1'b1;
  int         busy = 0;
  bit         busy_read = 1'b0;
  logic [7:0] held_byte = 8'h00;
  int         unstable = 0;
  int         ev_q[$];
  int         ev_cyc[$];
  int         done_q[$];
  int         exp_q[$];
  logic [7:0] rd_log[$];
  logic [7:0] rd_script[$];
  int         rsp_cnt = 0;
  logic [15:0] rsp_d = '0;
  logic       rsp_e = 1'b0;
  int         rsp_cyc = 0;
  logic       rdy_at_rsp = 1'b0;

  // Ready drops combinationally while any strobe is high.
  assign bdm_ready = eng_idle & ~hold_rdy & ~(bdm_do_write | bdm_do_read | bdm_do_delay);

  // Engine model and response monitor, evaluated 1ns after each rising edge.
  initial begin
    bdm_valid    = 1'b0;
    bdm_data_out = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bdm_valid = 1'b0;
      if (rst) begin
        busy     = 0;
        eng_idle = 1'b1;
      end else if (bdm_do_write | bdm_do_read | bdm_do_delay) begin
        ev_q.push_back(int'({bdm_do_read, bdm_do_delay, bdm_do_write}) * 256 +
                       (bdm_do_read ? 0 : int'(bdm_data_in)));
        ev_cyc.push_back(cyc);
        busy      = $urandom_range(1, 4);
        busy_read = bdm_do_read;
        held_byte = bdm_data_in;
        eng_idle  = 1'b0;
      end else if (busy > 0) begin
        if (!busy_read && bdm_data_in !== held_byte) unstable++;
        busy--;
        if (busy == 0) begin
          eng_idle = 1'b1;
          done_q.push_back(cyc);
          if (busy_read) begin
            bdm_valid    = 1'b1;
            bdm_data_out = (rd_script.size() > 0) ? rd_script.pop_front() : 8'($urandom);
            rd_log.push_back(bdm_data_out);
          end
        end else if (!busy_read && stray_en && $urandom_range(0, 3) == 0) begin
          bdm_valid    = 1'b1;
          bdm_data_out = 8'hEE;
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_d      = rsp_data;
        rsp_e      = rsp_error;
        rsp_cyc    = cyc;
        rdy_at_rsp = cmd_ready;
      end
    end
  end

  // Reference step list: opcode, address hi/lo, write bytes, delay, reads.
  function automatic void build_exp(input logic [7:0] op, input logic ha, input logic [15:0] ad,
                                    input logic [1:0] wl, input logic [15:0] wd,
                                    input logic [7:0] dl, input logic [1:0] rl);
    int w = (wl > 2) ? 2 : int'(wl);
    int r = (rl > 2) ? 2 : int'(rl);
    exp_q.delete();
    exp_q.push_back(256 + int'(op));
    if (ha) begin
      exp_q.push_back(256 + int'(ad[15:8]));
      exp_q.push_back(256 + int'(ad[7:0]));
    end
    for (int i = 0; i < w; i++)
      exp_q.push_back(256 + ((w == 2 && i == 0) ? int'(wd[15:8]) : int'(wd[7:0])));
    if (dl != 8'h00) exp_q.push_back(512 + int'(dl));
    for (int i = 0; i < r; i++) exp_q.push_back(1024);
  endfunction

  function automatic logic [15:0] exp_rsp(input logic [1:0] rl);
    int r = (rl > 2) ? 2 : int'(rl);
    if (r == 0 || rd_log.size() < r) return 16'h0000;
    if (r == 1) return {8'h00, rd_log[0]};
    return {rd_log[0], rd_log[1]};
  endfunction

  function automatic int ev_mismatch();
    int m = 0;
    if (ev_q.size() != exp_q.size()) return 1000 + ev_q.size();
    foreach (exp_q[i]) if (ev_q[i] != exp_q[i]) m++;
    return m;
  endfunction

  task automatic clear_logs();
    ev_q.delete(); ev_cyc.delete(); done_q.delete(); rd_log.delete();
    unstable = 0;
  endtask

  task automatic drive_garbage();
    cmd_opcode = 8'($urandom); cmd_has_addr = 1'($urandom); cmd_addr = 16'($urandom);
    cmd_wr_len = 2'($urandom); cmd_wdata = 16'($urandom); cmd_delay = 8'($urandom);
    cmd_rd_len = 2'($urandom);
  endtask

  task automatic drive_fields(input logic [7:0] op, input logic ha, input logic [15:0] ad,
                              input logic [1:0] wl, input logic [15:0] wd,
                              input logic [7:0] dl, input logic [1:0] rl);
    cmd_opcode = op; cmd_has_addr = ha; cmd_addr = ad; cmd_wr_len = wl;
    cmd_wdata = wd; cmd_delay = dl; cmd_rd_len = rl;
  endtask

  // Presents a command and returns the edge number at which it is accepted.
  task automatic send_cmd(input logic [7:0] op, input logic ha, input logic [15:0] ad,
                          input logic [1:0] wl, input logic [15:0] wd,
                          input logic [7:0] dl, input logic [1:0] rl,
                          output int acc, output bit ok);
    drive_fields(op, ha, ad, wl, wd, dl, rl);
    cmd_valid = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (cmd_ready) begin ok = 1'b1; acc = cyc + 1; end
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    drive_garbage();
  endtask

  task automatic wait_rsp(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (rsp_cnt > n0) ok = 1'b1;
      else begin @(posedge clk); #2; end
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic ha, input logic [15:0] ad,
                         input logic [1:0] wl, input logic [15:0] wd,
                         input logic [7:0] dl, input logic [1:0] rl,
                         output int acc, output bit ok);
    int n0;
    bit a_ok;
    clear_logs();
    build_exp(op, ha, ad, wl, wd, dl, rl);
    n0 = rsp_cnt;
    send_cmd(op, ha, ad, wl, wd, dl, rl, acc, a_ok);
    if (a_ok) wait_rsp(n0, ok);
    else ok = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++;
    if ({bdm_do_write, bdm_do_read, bdm_do_delay} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {bdm_do_write, bdm_do_read, bdm_do_delay});
    end
    checks++;
    if (bdm_data_in !== 8'h00 || rsp_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: data_in=%h rsp_data=%h want 00/0000", bdm_data_in, rsp_data);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: valid=%b error=%b want 0/0", rsp_valid, rsp_error);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_spec_vectors();
    int acc;
    bit ok;
    // Single read after the opcode.
    rd_script.delete(); rd_script.push_back(8'hC8);
    run_cmd(8'hE4, 1'b0, 16'h0000, 2'd0, 16'h0000, 8'h00, 2'd1, acc, ok);
    checks++;
    if (!ok || ev_mismatch() != 0) begin errors++; $display("FAIL vec1_steps: ok=%b mism=%0d", ok, ev_mismatch()); end
    checks++;
    if (rsp_d !== 16'h00C8 || rsp_e !== 1'b0) begin
      errors++; $display("FAIL vec1_rsp: got %h err=%b want 00c8 err=0", rsp_d, rsp_e);
    end
    checks++;
    if (ev_cyc.size() == 0 || ev_cyc[0] != acc + 1) begin
      errors++; $display("FAIL vec1_first_strobe: got cyc %0d want %0d", ev_cyc.size() ? ev_cyc[0] : -1, acc + 1);
    end
    @(posedge clk); #2;
    // Address, one write byte and a delay, no reads.
    run_cmd(8'h4B, 1'b1, 16'h1234, 2'd1, 16'h0055, 8'h10, 2'd0, acc, ok);
    checks++;
    if (!ok || ev_q.size() != 5 || ev_q[0] != 'h14B || ev_q[1] != 'h112 || ev_q[2] != 'h134 ||
        ev_q[3] != 'h155 || ev_q[4] != 'h210) begin
      errors++; $display("FAIL vec2_steps: ok=%b n=%0d want 5 steps 4B 12 34 55 D10", ok, ev_q.size());
    end
    checks++;
    if (rsp_d !== 16'h0000 || rsp_e !== 1'b0) begin
      errors++; $display("FAIL vec2_rsp: got %h err=%b want 0000 err=0", rsp_d, rsp_e);
    end
    @(posedge clk); #2;
    // Two reads packed first-byte-high.
    rd_script.delete(); rd_script.push_back(8'hAB); rd_script.push_back(8'hCD);
    run_cmd(8'hE5, 1'b0, 16'h0000, 2'd0, 16'h0000, 8'h00, 2'd2, acc, ok);
    checks++;
    if (!ok || ev_mismatch() != 0) begin errors++; $display("FAIL vec3_steps: ok=%b mism=%0d", ok, ev_mismatch()); end
    checks++;
    if (rsp_d !== 16'hABCD) begin errors++; $display("FAIL vec3_rsp: got %h want abcd", rsp_d); end
    @(posedge clk); #2;
  endtask

  task automatic test_random(input int n);
    int acc, n0, gap_bad;
    bit ok;
    logic [7:0] op, dl;
    logic ha;
    logic [15:0] ad, wd;
    logic [1:0] wl, rl;
    for (int k = 0; k < n; k++) begin
      op = 8'($urandom); ha = 1'($urandom); ad = 16'($urandom); wl = 2'($urandom);
      wd = 16'($urandom); rl = 2'($urandom);
      dl = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      n0 = rsp_cnt;
      run_cmd(op, ha, ad, wl, wd, dl, rl, acc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd%0d_rsp_timeout: no rsp_valid within bound", k); end
      checks++;
      if (ev_mismatch() != 0) begin
        errors++; $display("FAIL rnd%0d_steps: got %0d steps want %0d, mism=%0d", k, ev_q.size(), exp_q.size(), ev_mismatch());
      end
      checks++;
      if (rsp_d !== exp_rsp(rl) || rsp_e !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_rsp: got %h err=%b want %h err=0", k, rsp_d, rsp_e, exp_rsp(rl));
      end
      checks++;
      if (ev_cyc.size() == 0 || ev_cyc[0] != acc + 1) begin
        errors++; $display("FAIL rnd%0d_first_strobe: got %0d want %0d", k, ev_cyc.size() ? ev_cyc[0] : -1, acc + 1);
      end
      gap_bad = 0;
      for (int i = 1; i < ev_cyc.size(); i++)
        if (i - 1 >= done_q.size() || ev_cyc[i] != done_q[i-1] + 2) gap_bad++;
      checks++;
      if (gap_bad != 0) begin errors++; $display("FAIL rnd%0d_step_gap: %0d late/early strobes want 0", k, gap_bad); end
      checks++;
      if (done_q.size() == 0 || rsp_cyc != done_q[done_q.size()-1] + 1) begin
        errors++; $display("FAIL rnd%0d_rsp_latency: rsp at %0d want last done+1", k, rsp_cyc);
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL rnd%0d_data_hold: %0d changes want 0", k, unstable); end
      @(posedge clk); #2;
      checks++;
      if (rdy_at_rsp !== 1'b0 || cmd_ready !== 1'b1 || rsp_cnt != n0 + 1) begin
        errors++; $display("FAIL rnd%0d_ready: at_rsp=%b after=%b pulses=%0d want 0/1/1", k, rdy_at_rsp, cmd_ready, rsp_cnt - n0);
      end
    end
  endtask

  task automatic test_timeout();
    int acc;
    bit ok;
    hold_rdy = 1'b1;
    run_cmd(8'h5A, 1'b1, 16'hBEEF, 2'd2, 16'h1122, 8'h07, 2'd2, acc, ok);
    checks++;
    if (!ok || rsp_e !== 1'b1) begin errors++; $display("FAIL timeout_error: ok=%b err=%b want 1/1", ok, rsp_e); end
    checks++;
    if (rsp_cyc != acc + int'(TO)) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", rsp_cyc - acc, TO); end
    checks++;
    if (ev_q.size() != 0 || rsp_d !== 16'h0000) begin
      errors++; $display("FAIL timeout_no_strobe: strobes=%0d data=%h want 0/0000", ev_q.size(), rsp_d);
    end
    hold_rdy = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int acc, n0;
    bit ok, seen;
    clear_logs();
    n0 = rsp_cnt;
    send_cmd(8'h33, 1'b1, 16'hA55A, 2'd2, 16'h7788, 8'h09, 2'd2, acc, ok);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (ev_q.size() >= 2) seen = 1'b1;
      else begin @(posedge clk); #2; end
    end
    checks++;
    if (!ok || !seen) begin errors++; $display("FAIL rstmid_setup: acc=%b second_strobe=%b want 1/1", ok, seen); end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready: ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
    end
    repeat (30) begin @(posedge clk); #2; end
    checks++;
    if (ev_q.size() != 2 || rsp_cnt != n0) begin
      errors++; $display("FAIL rstmid_quiet: strobes=%0d rsp=%0d want 2/0", ev_q.size(), rsp_cnt - n0);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, rc1, n0;
    bit ok, got;
    int exp1[$];
    logic [7:0] op2 = 8'($urandom);
    logic [15:0] ad2 = 16'($urandom);
    logic [15:0] wd2 = 16'($urandom);
    clear_logs();
    build_exp(8'h61, 1'b1, 16'h4321, 2'd3, 16'h9abc, 8'h02, 2'd0);
    exp1 = exp_q;
    n0 = rsp_cnt;
    send_cmd(8'h61, 1'b1, 16'h4321, 2'd3, 16'h9abc, 8'h02, 2'd0, acc1, ok);
    // Hold a second command with churning fields until the sequencer is ready.
    cmd_valid = 1'b1;
    got = 1'b0; acc2 = 0; rc1 = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        drive_fields(op2, 1'b1, ad2, 2'd1, wd2, 8'h00, 2'd2);
        acc2 = cyc + 1;
        rc1  = rsp_cyc;
      end else begin
        drive_garbage();
      end
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok || !got || rsp_cnt != n0 + 1 || acc2 != rc1 + 2) begin
      errors++; $display("FAIL b2b_accept: acc_edge=%0d want rsp+2=%0d rsp=%0d", acc2, rc1 + 2, rsp_cnt - n0);
    end
    wait_rsp(n0 + 1, ok);
    build_exp(op2, 1'b1, ad2, 2'd1, wd2, 8'h00, 2'd2);
    exp_q = {exp1, exp_q};
    checks++;
    if (!ok || ev_mismatch() != 0) begin
      errors++; $display("FAIL b2b_steps: ok=%b got %0d steps want %0d mism=%0d", ok, ev_q.size(), exp_q.size(), ev_mismatch());
    end
    checks++;
    if (rsp_d !== exp_rsp(2'd2) || rsp_e !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp: got %h err=%b want %h err=0", rsp_d, rsp_e, exp_rsp(2'd2));
    end
    @(posedge clk); #2;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    drive_fields(8'h00, 1'b0, 16'h0000, 2'd0, 16'h0000, 8'h00, 2'd0);
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    test_spec_vectors();
    test_random(40);
    test_timeout();
    test_reset_mid();
    test_random(5);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
